// File: rtl/life_board_controller.sv
// ---------------------------------------------------------------------------
// LifeBoardController
//
// Owns the 16x16 Game-of-Life board register and sequences generations
// through an external, registered generation-step module. The board is
// driven out continuously; a one-cycle alg_select pulse asks the step module
// to compute the next generation. The result is captured one cycle later.
//
// Generations are paced either by a free-running tick divider (run_i=1) or
// by single-step requests (step_i pulses while run_i=0). Individual cells
// can be written through a valid/ready interface while the controller is
// idle and not free-running.
//
// Ports:
//   clk_i          system clock, all state on posedge
//   rst_ni         asynchronous active-low reset
//   run_i          level, 1 = free-run generations every TICK_DIV+2 cycles
//   step_i         pulse, request one generation (ignored while run_i=1)
//   clear_i        pulse, empty the board and zero the generation counter
//   wr_valid_i     cell write request
//   wr_ready_o     controller accepts a write this cycle
//   wr_row_i       cell row 0..15
//   wr_col_i       cell column 0..15
//   wr_val_i       value written to the cell
//   board_state_o  current board, bit index = row*16+col
//   alg_select_o   step-module enable, high for one cycle per generation
//   alg_result_i   step-module registered output
//   gen_count_o    generations committed since reset/clear, wraps
//   extinct_o      1 when the board is empty
//   stable_o       1 when the last commit left the board unchanged
//   busy_o         1 while a generation is in flight (EVAL or COMMIT)
// ---------------------------------------------------------------------------
module life_board_controller #(
   parameter int TICK_DIV = 25000000,
   parameter int GEN_W    = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               run_i,
   input  logic               step_i,
   input  logic               clear_i,
   input  logic               wr_valid_i,
   output logic               wr_ready_o,
   input  logic [3:0]         wr_row_i,
   input  logic [3:0]         wr_col_i,
   input  logic               wr_val_i,
   output logic [255:0]       board_state_o,
   output logic               alg_select_o,
   input  logic [255:0]       alg_result_i,
   output logic [GEN_W-1:0]   gen_count_o,
   output logic               extinct_o,
   output logic               stable_o,
   output logic               busy_o
);

   // Tick counter only needs to reach TICK_DIV-1; keep at least one bit so
   // TICK_DIV=1 still elaborates.
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EVAL   = 2'd1,
      COMMIT = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [255:0]       board_q, board_d;
   logic [GEN_W-1:0]   gen_q, gen_d;
   logic [TW-1:0]      tick_q, tick_d;
   logic               extinct_q, extinct_d;
   logic               stable_q, stable_d;
   logic               sel_q, sel_d;
   logic               busy_q, busy_d;
   logic [7:0]         wrIndex;

   // Row-major cell index: {row, col} is exactly row*16+col in 8 bits.
   assign wrIndex = {wr_row_i, wr_col_i};

   // Writes are only taken while idle and not free-running; the requester
   // holds wr_valid_i until it sees ready.
   assign wr_ready_o = (state_q == IDLE) && !run_i;

   // Next-state logic. clear_i overrides everything, in any state, so an
   // in-flight result is simply dropped. In IDLE a cell write beats a
   // generation trigger. The tick counter only runs while run_i is high
   // and is forced back to zero otherwise.
   always_comb begin
      state_d   = state_q;
      board_d   = board_q;
      gen_d     = gen_q;
      tick_d    = run_i ? tick_q : '0;
      extinct_d = extinct_q;
      stable_d  = stable_q;
      sel_d     = 1'b0;
      busy_d    = 1'b0;

      if (clear_i) begin
         state_d   = IDLE;
         board_d   = '0;
         gen_d     = '0;
         tick_d    = '0;
         extinct_d = 1'b1;
         stable_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (wr_valid_i && wr_ready_o) begin
                  board_d[wrIndex] = wr_val_i;
                  extinct_d        = (board_d == '0);
                  stable_d         = 1'b0;
               end else if (run_i) begin
                  if (tick_q == TICK_LAST) begin
                     tick_d  = '0;
                     state_d = EVAL;
                     sel_d   = 1'b1;
                     busy_d  = 1'b1;
                  end else begin
                     tick_d = tick_q + 1'b1;
                  end
               end else if (step_i) begin
                  state_d = EVAL;
                  sel_d   = 1'b1;
                  busy_d  = 1'b1;
               end
            end
            EVAL: begin
               state_d = COMMIT;
               busy_d  = 1'b1;
            end
            COMMIT: begin
               state_d   = IDLE;
               board_d   = alg_result_i;
               gen_d     = gen_q + 1'b1;
               stable_d  = (alg_result_i == board_q);
               extinct_d = (alg_result_i == '0);
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State register. alg_select and busy are registered alongside the state
   // so they are glitch-free and exactly track EVAL / EVAL+COMMIT.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         board_q   <= '0;
         gen_q     <= '0;
         tick_q    <= '0;
         extinct_q <= 1'b1;
         stable_q  <= 1'b0;
         sel_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         board_q   <= board_d;
         gen_q     <= gen_d;
         tick_q    <= tick_d;
         extinct_q <= extinct_d;
         stable_q  <= stable_d;
         sel_q     <= sel_d;
         busy_q    <= busy_d;
      end
   end

   assign board_state_o = board_q;
   assign gen_count_o   = gen_q;
   assign extinct_o     = extinct_q;
   assign stable_o      = stable_q;
   assign alg_select_o  = sel_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_life_board_controller.sv
// ---------------------------------------------------------------------------
// tb_life_board_controller
//
// Bench for LifeBoardController. Plays the role of the generation-step
// module (a registered Life-rule evaluator enabled by alg_select) and keeps
// a cell-array model of the board, generation count and status flags.
// ---------------------------------------------------------------------------
module tb_life_board_controller;

   logic          clk = 1'b0;
   logic          rstN;
   logic          run, step, clear, wrValid, wrVal;
   logic          wrReady;
   logic [3:0]    wrRow, wrCol;
   logic [255:0]  boardState, algResult;
   logic          algSelect, extinct, stable, busy;
   logic [15:0]   genCount;

   int            compareCount = 0;
   int            mismatchCount = 0;

   // Reference model: plain cell grid plus counters.
   bit            cells [16][16];
   int            modelGen;
   bit            modelExtinct, modelStable;

   life_board_controller #(.TICK_DIV(4), .GEN_W(16)) dut (
      .clk_i(clk), .rst_ni(rstN), .run_i(run), .step_i(step), .clear_i(clear),
      .wr_valid_i(wrValid), .wr_ready_o(wrReady), .wr_row_i(wrRow),
      .wr_col_i(wrCol), .wr_val_i(wrVal), .board_state_o(boardState),
      .alg_select_o(algSelect), .alg_result_i(algResult),
      .gen_count_o(genCount), .extinct_o(extinct), .stable_o(stable),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   // Conway rule on a bounded 16x16 grid (no wraparound).
   function automatic logic [255:0] lifeNext(input logic [255:0] b);
      logic [255:0] n;
      int cnt, rr, cc;
      n = '0;
      for (int r = 0; r < 16; r++) begin
         for (int c = 0; c < 16; c++) begin
            cnt = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  rr = r + dr;
                  cc = c + dc;
                  if ((dr != 0 || dc != 0) && rr >= 0 && rr < 16 && cc >= 0 && cc < 16)
                     if (b[rr*16+cc]) cnt++;
               end
            end
            n[r*16+c] = b[r*16+c] ? (cnt == 2 || cnt == 3) : (cnt == 3);
         end
      end
      return n;
   endfunction

   // Stand-in for the generation-step module: registered, enabled by select.
   always @(posedge clk or negedge rstN) begin
      if (!rstN) algResult <= '0;
      else if (algSelect) algResult <= lifeNext(boardState);
   end

   function automatic logic [255:0] packModel();
      logic [255:0] p;
      p = '0;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            p[r*16+c] = cells[r][c];
      return p;
   endfunction

   task automatic modelReset();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            cells[r][c] = 1'b0;
      modelGen     = 0;
      modelExtinct = 1'b1;
      modelStable  = 1'b0;
   endtask

   task automatic modelWrite(input int r, input int c, input bit v);
      cells[r][c]  = v;
      modelExtinct = (packModel() == '0);
      modelStable  = 1'b0;
   endtask

   task automatic modelStep();
      logic [255:0] cur, nxt;
      cur = packModel();
      nxt = lifeNext(cur);
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            cells[r][c] = nxt[r*16+c];
      modelStable  = (nxt == cur);
      modelExtinct = (nxt == '0);
      modelGen     = (modelGen + 1) % 65536;
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Full idle-state comparison against the model.
   task automatic checkAll(input string tag);
      checkOutput({tag, ".board"},   boardState, packModel());
      checkOutput({tag, ".gen"},     256'(genCount), 256'(modelGen));
      checkOutput({tag, ".extinct"}, 256'(extinct), 256'(modelExtinct));
      checkOutput({tag, ".stable"},  256'(stable), 256'(modelStable));
      checkOutput({tag, ".busy"},    256'(busy), 256'(0));
      checkOutput({tag, ".ready"},   256'(wrReady), 256'(1));
      checkOutput({tag, ".select"},  256'(algSelect), 256'(0));
   endtask

   task automatic applyWrite(input int r, input int c, input bit v);
      @(posedge clk); #1;
      wrValid = 1'b1; wrRow = 4'(r); wrCol = 4'(c); wrVal = v;
      @(posedge clk); #1;
      wrValid = 1'b0;
      modelWrite(r, c, v);
      @(negedge clk);
   endtask

   // One step pulse; select must be high for exactly one cycle, then the
   // board settles to the next generation.
   task automatic applyStep(input string tag);
      int selCycles;
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      selCycles = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) checkOutput({tag, ".busyEval"}, 256'(busy), 256'(1));
         if (algSelect) selCycles++;
      end
      checkOutput({tag, ".selWidth"}, 256'(selCycles), 256'(1));
      modelStep();
      checkAll(tag);
   endtask

   task automatic applyClear();
      @(posedge clk); #1 clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      modelReset();
      @(negedge clk);
   endtask

   // Random operation: mostly writes into a central patch, sometimes a step.
   task automatic applyStimulus(input int idx);
      int r, c;
      bit v;
      if ($urandom_range(0, 2) != 0) begin
         r = $urandom_range(5, 10);
         c = $urandom_range(5, 10);
         v = ($urandom_range(0, 3) != 0);
         applyWrite(r, c, v);
         checkAll($sformatf("rand%0d.write", idx));
      end else begin
         applyStep($sformatf("rand%0d.step", idx));
      end
   endtask

   initial begin
      logic [255:0] expBoard;
      int pulses [$];
      int readyHigh, heldPulses;

      rstN = 1'b0; run = 1'b0; step = 1'b0; clear = 1'b0;
      wrValid = 1'b0; wrRow = '0; wrCol = '0; wrVal = 1'b0;
      modelReset();

      // Reset values.
      repeat (2) @(negedge clk);
      checkAll("reset");
      rstN = 1'b1;
      @(negedge clk);

      // Blinker.
      applyWrite(7, 6, 1'b1);
      applyWrite(7, 7, 1'b1);
      applyWrite(7, 8, 1'b1);
      expBoard = '0; expBoard[118] = 1'b1; expBoard[119] = 1'b1; expBoard[120] = 1'b1;
      checkOutput("blinker.written", boardState, expBoard);
      checkOutput("blinker.extinct0", 256'(extinct), 256'(0));
      applyStep("blinker.s1");
      expBoard = '0; expBoard[103] = 1'b1; expBoard[119] = 1'b1; expBoard[135] = 1'b1;
      checkOutput("blinker.vert", boardState, expBoard);
      checkOutput("blinker.gen1", 256'(genCount), 256'(1));
      applyStep("blinker.s2");
      expBoard = '0; expBoard[118] = 1'b1; expBoard[119] = 1'b1; expBoard[120] = 1'b1;
      checkOutput("blinker.horiz", boardState, expBoard);
      checkOutput("blinker.gen2", 256'(genCount), 256'(2));

      // Step held high: one generation every 3 cycles.
      @(posedge clk); #1 step = 1'b1;
      heldPulses = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         if (algSelect) heldPulses++;
      end
      @(posedge clk); #1 step = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (algSelect) heldPulses++;
      end
      checkOutput("held.pulses", 256'(heldPulses), 256'(3));
      repeat (3) modelStep();
      checkAll("held");

      // Block still life.
      applyClear();
      checkAll("clear1");
      applyWrite(0, 0, 1'b1);
      applyWrite(0, 1, 1'b1);
      applyWrite(1, 0, 1'b1);
      applyWrite(1, 1, 1'b1);
      applyStep("block");
      checkOutput("block.stable", 256'(stable), 256'(1));

      // Free-run with TICK_DIV=4 while a write is held pending.
      @(posedge clk); #1;
      run = 1'b1; wrValid = 1'b1; wrRow = 4'd10; wrCol = 4'd10; wrVal = 1'b1;
      readyHigh = 0;
      for (int cyc = 0; cyc < 60; cyc++) begin
         if (cyc == 40) begin
            @(posedge clk); #1 run = 1'b0; wrValid = 1'b0;
         end
         @(negedge clk);
         if (algSelect) pulses.push_back(cyc);
         if (cyc < 40 && wrReady) readyHigh++;
      end
      checkOutput("run.readyHigh", 256'(readyHigh), 256'(0));
      checkOutput("run.pulseCount", 256'(pulses.size()), 256'(7));
      if (pulses.size() > 0)
         checkOutput("run.firstPulse", 256'(pulses[0]), 256'(4));
      for (int i = 1; i < pulses.size(); i++)
         checkOutput($sformatf("run.period%0d", i), 256'(pulses[i] - pulses[i-1]), 256'(6));
      for (int i = 0; i < pulses.size(); i++) modelStep();
      checkAll("run.after");

      // Clear while alg_select is high: no commit follows.
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0; clear = 1'b1;
      @(negedge clk);
      checkOutput("clrEval.sel", 256'(algSelect), 256'(1));
      @(posedge clk); #1 clear = 1'b0;
      modelReset();
      @(negedge clk);
      checkAll("clrEval.next");
      repeat (4) @(negedge clk);
      checkAll("clrEval.later");

      // Clear and write together: clear wins.
      @(posedge clk); #1;
      clear = 1'b1; wrValid = 1'b1; wrRow = 4'd3; wrCol = 4'd3; wrVal = 1'b1;
      @(posedge clk); #1 clear = 1'b0; wrValid = 1'b0;
      @(negedge clk);
      checkAll("clrWrite");

      // Lone cell dies; writing a zero to an empty board keeps extinct.
      applyWrite(15, 15, 1'b1);
      checkOutput("lone.extinct0", 256'(extinct), 256'(0));
      applyStep("lone");
      checkOutput("lone.empty", boardState, 256'(0));
      applyWrite(15, 15, 1'b0);
      checkOutput("lone.extinctKept", 256'(extinct), 256'(1));

      // Asynchronous reset in the middle of EVAL.
      applyWrite(4, 4, 1'b1);
      @(posedge clk); #1 step = 1'b1;
      @(posedge clk); #1 step = 1'b0;
      @(negedge clk);
      checkOutput("asyncRst.inEval", 256'(algSelect), 256'(1));
      #1 rstN = 1'b0;
      #1;
      modelReset();
      checkAll("asyncRst");
      @(negedge clk); #1 rstN = 1'b1;
      @(negedge clk);
      checkAll("asyncRst.release");

      // Randomized writes and steps against the model.
      for (int i = 0; i < 30; i++) applyStimulus(i);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule
